// File: rtl/keccak_chi_seq.sv
// Sequential Keccak chi step: loads a 25-lane state, applies chi in place
// PLANES_PER_CYCLE planes per clock. Optional op counter: KECCAK_CHI_OPCNT_EN.
module keccak_chi_seq #(
    parameter int unsigned LANE_W           = 64,
    parameter int unsigned PLANES_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [25*LANE_W-1:0]  state_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [25*LANE_W-1:0]  state_out,
    output logic                  busy
`ifdef KECCAK_CHI_OPCNT_EN
    ,
    output logic [31:0]           ops_count
`endif
);

    localparam int unsigned S     = 25 * LANE_W;
    localparam int unsigned ROW_W = 5 * LANE_W;
    localparam int unsigned NP    = 5 / PLANES_PER_CYCLE;
    localparam int unsigned CW    = (NP > 1) ? $clog2(NP) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic            load;
    logic            last;
    logic [CW-1:0]   plane_cnt;
    logic [S-1:0]    state_reg;
    logic [S-1:0]    state_chi;

    // chi is confined to one 5-lane row, so each plane can be rewritten alone
    function automatic logic [ROW_W-1:0] chi_row(input logic [ROW_W-1:0] r);
        logic [ROW_W-1:0] o;
        o = '0;
        for (int unsigned x = 0; x < 5; x++) begin
            for (int unsigned z = 0; z < LANE_W; z++) begin
                o[x*LANE_W+z] = r[x*LANE_W+z]
                              ^ (~r[((x+1)%5)*LANE_W+z] & r[((x+2)%5)*LANE_W+z]);
            end
        end
        return o;
    endfunction

    assign last = (plane_cnt == CW'(NP - 1));

    always_comb begin
        state_chi = state_reg;
        for (int unsigned y = 0; y < 5; y++) begin
            if (plane_cnt == CW'(y / PLANES_PER_CYCLE)) begin
                state_chi[y*ROW_W +: ROW_W] = chi_row(state_reg[y*ROW_W +: ROW_W]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // DONE forwards out_ready to in_ready so a new state can load on the drain edge
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        load     = 1'b1;
                        state_nx = RUN;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= '0;
            plane_cnt <= '0;
        end else if (load) begin
            state_reg <= state_in;
            plane_cnt <= '0;
        end else if (state == RUN) begin
            state_reg <= state_chi;
            plane_cnt <= last ? '0 : plane_cnt + 1'b1;
        end
    end

    assign state_out = state_reg;

`ifdef KECCAK_CHI_OPCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_count <= '0;
        end else if (out_valid && out_ready) begin
            ops_count <= ops_count + 32'd1;
        end
    end
`endif

endmodule
